// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state and transaction owner
// encodings, plus the word size code used for instruction fetches.
package mem_arbiter_pkg;

    // Arbiter FSM states; IDLE is the all-zero reset encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Which requester owns the transaction currently on the memory port.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_LSU  = 2'd2
    } arb_owner_e;

    // Size code driven for instruction fetches (always a full word).
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Memory-port arbiter between instruction fetch (IF) and the load/store unit.
// Fixed priority LSU over IF; one transaction at a time through
// IDLE -> BUSY -> RESP. Optional BUSY timeout guarded by MEM_ARB_TIMEOUT_EN.
//
// Handshake: a requester raises i_*_req and keeps it (and its fields) stable
// until its o_*_valid pulse; the memory sees o_mem_req high for the whole
// BUSY window and completes it with a single-cycle i_mem_ack, with
// i_mem_rdata sampled in that same cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // instruction fetch side
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    // load/store side
    input  logic              i_lsu_req,
    input  logic              i_lsu_we,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [1:0]        i_lsu_size,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    output logic [DATA_W-1:0] o_lsu_rdata,
    output logic              o_lsu_valid,
    // memory side
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [1:0]        o_mem_size,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_err,
    // pipeline
    output logic              o_stall,
    // debug visibility of the FSM
    output arb_state_e        o_state,
    output arb_owner_e        o_owner
);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    arb_owner_e        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_lsu_rdata;
    logic              w_grant_lsu;
    logic              w_grant_if;
    logic              w_complete;
    logic              w_timeout;
    logic [DATA_W-1:0] w_rdata_in;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Count BUSY cycles without an ack; cleared whenever not in BUSY so
    // every entry into BUSY starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != BUSY) begin
            r_tmo_cnt <= '0;
        end else if (!i_mem_ack) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (r_state == BUSY && w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign w_timeout = (r_tmo_cnt == TMO_LAST) && !i_mem_ack;
    assign o_mem_err = r_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
    assign o_mem_err    = 1'b0;
`endif

    // Stores and aborted (timed-out) transactions return zero data.
    assign w_rdata_in = (i_mem_ack && !r_we) ? i_mem_rdata : '0;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decode; LSU wins when both request in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_grant_lsu  = 1'b0;
        w_grant_if   = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_lsu_req) begin
                    w_grant_lsu  = 1'b1;
                    w_next_state = BUSY;
                end else if (i_if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_ack || w_timeout) begin
                    w_complete   = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the winning request, track the owner and latch returned data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner     <= OWNER_NONE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_lsu_rdata <= '0;
        end else begin
            if (w_grant_lsu) begin
                r_owner <= OWNER_LSU;
                r_we    <= i_lsu_we;
                r_addr  <= i_lsu_addr;
                r_size  <= i_lsu_size;
                r_wdata <= i_lsu_wdata;
            end else if (w_grant_if) begin
                r_owner <= OWNER_IF;
                r_we    <= 1'b0;
                r_addr  <= i_if_addr;
                r_size  <= SIZE_WORD;
                r_wdata <= '0;
            end else if (r_state == RESP) begin
                r_owner <= OWNER_NONE;
            end
            if (w_complete && r_owner == OWNER_IF) begin
                r_if_rdata <= w_rdata_in;
            end
            if (w_complete && r_owner == OWNER_LSU) begin
                r_lsu_rdata <= w_rdata_in;
            end
        end
    end

    assign o_mem_req   = (r_state == BUSY);
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_size  = r_size;
    assign o_mem_wdata = r_wdata;
    assign o_if_valid  = (r_state == RESP) && (r_owner == OWNER_IF);
    assign o_lsu_valid = (r_state == RESP) && (r_owner == OWNER_LSU);
    assign o_if_rdata  = r_if_rdata;
    assign o_lsu_rdata = r_lsu_rdata;
    assign o_stall     = (i_if_req & ~o_if_valid) | (i_lsu_req & ~o_lsu_valid);
    assign o_state     = r_state;
    assign o_owner     = r_owner;

endmodule
